oled_spi_rx: RTL and testbench
==============================

// Module: oled_spi_rx
// PURPOSE
// - SPI target (receiver) for the 4-wire OLED link (CS_N, SCLK, MOSI, D/C); the other end of the OLED controller's SPI master.
// - Oversamples the link in the local clk domain and deserialises bytes MSB-first.
// - Tags each byte as command (dc=0) or data (dc=1) and buffers it in a small FIFO.
// - Drains through a valid/ready port; used as a loopback checker and display-model front end.
// PARAMETERS
// - FIFO_DEPTH   4   entries in byte FIFO; power of 2, >=2
// - SYNC_STAGES  2   synchroniser flops on each SPI input; >=2
// PORTS
// - clk              in   1   system clock; all logic on rising edge
// - rst_n            in   1   asynchronous active-low reset
// - spi_cs_n         in   1   chip select, active low, async to clk
// - spi_sclk         in   1   SPI clock, mode 0 (idle low, sample on rising edge); f_sclk <= f_clk/4
// - spi_mosi         in   1   serial data, MSB first
// - oled_dc          in   1   0=command, 1=data; sampled with bit 0 of each byte
// - rx_data          out  8   head-of-FIFO byte
// - rx_is_data       out  1   D/C tag of head byte
// - rx_valid         out  1   FIFO non-empty
// - rx_ready         in   1   consumer accepts head when rx_valid & rx_ready
// - overflow         out  1   sticky: a completed byte was dropped
// - clear_overflow   in   1   clears overflow
// - frag_err         out  1   1-cycle pulse: CS_N rose with 1..7 bits shifted
// - byte_count       out  16  bytes pushed since reset; wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs 0; FIFO empty; bit counter 0; shift reg 0; sync chains load idle values (cs_n=1, sclk=0).
// - Sync: cs_n, sclk, mosi, dc each pass SYNC_STAGES flops; sclk_rise = sync_sclk & ~sclk_q.
// - Shift: on sclk_rise with sync_cs_n=0, shift = {shift[6:0], mosi}; bit_cnt++ (3 bit).
// - On the 8th rise (bit_cnt==7): push {dc, shift[6:0], mosi} next cycle; bit_cnt->0; byte_count++.
// - Latency: rx_valid rises 1 clk after the push cycle (registered FIFO output).
//   - Empty FIFO: rx_valid is high 2 clk after the detected 8th edge.
// - Frame: sync_cs_n rising edge with bit_cnt!=0 -> partial byte discarded, bit_cnt->0, frag_err pulses 1 clk.
//   - CS_N high with bit_cnt==0 is silent.
//   - sclk edges while CS_N high are ignored.
// - Back-to-back bytes within one CS_N low window are legal; no gap required.
// - FIFO push and pop:
//   - pop = rx_valid & rx_ready.
//   - Push when full with no pop in the same cycle: byte dropped, overflow<=1, byte_count still increments.
//   - Push when full with pop in the same cycle: both occur, count unchanged, no overflow.
//   - Pop when empty: no effect.
// - overflow: set has priority over clear_overflow in the same cycle.
// - rx_data/rx_is_data are stable while rx_valid=1 and rx_ready=0.
// - Reset mid-byte or mid-frame: all state lost; first byte after reset release needs a fresh CS_N low.
// - No output depends combinationally on SPI pins.
// STRUCTURE
// - Shared package oled_pkg:
//   - OLED_DC_CMD=1'b0, OLED_DC_DATA=1'b1
//   - typedef oled_byte_t = {logic dc; logic [7:0] data} (9 bits)
//   - SPI_BITS_PER_BYTE=8
// - Sub-module: oled_sync_fifo (WIDTH=9, DEPTH=FIFO_DEPTH) with push/pop/full/empty and registered output.
// - Top of block: synchronisers, edge detect, shift/bit counter, frame tracking, counters.
// TESTING
// - Reset, then CS_N low, send 0xAF with dc=0, CS_N high -> rx_valid=1, rx_data=0xAF, rx_is_data=0, byte_count=1, frag_err=0.
// - One CS_N window, dc=1, bytes 0x68,0x65,0x6C,0x6C,0x6F, rx_ready=1 -> popped in order with rx_is_data=1; byte_count=5.
// - rx_ready=0, send 5 bytes 0x01..0x05 (FIFO_DEPTH=4) -> FIFO holds 0x01..0x04, overflow=1, byte_count=5; clear_overflow -> 0.
// - Send 5 sclk edges then raise CS_N -> frag_err pulses once, no push; next full byte 0x3C is received intact.
// - Drive sclk edges with CS_N high -> no push; assert rst_n=0 after 4 bits -> outputs 0; next complete byte is received correctly.
// - FIFO full with rx_ready=1 as the 8th edge lands -> push and pop in the same cycle, overflow stays 0.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI link: D/C tag values, the tagged byte type
// and the frame geometry.
package oled_pkg;

    localparam logic OLED_DC_CMD       = 1'b0;
    localparam logic OLED_DC_DATA      = 1'b1;
    localparam int   SPI_BITS_PER_BYTE = 8;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } oled_byte_t;

endpackage

// File: rtl/oled_sync_fifo.sv
// Single-clock FIFO with flop storage; the head entry is read straight from the
// storage flops, so dout/empty never depend combinationally on push.
module oled_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/oled_spi_rx.sv
// SPI mode-0 target for the OLED link: oversamples CS_N/SCLK/MOSI/DC in clk,
// deserialises MSB-first bytes tagged with D/C and queues them for a valid/ready consumer.
module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        oled_dc,
    output logic [7:0]  rx_data,
    output logic        rx_is_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        overflow,
    input  logic        clear_overflow,
    output logic        frag_err,
    output logic [15:0] byte_count
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BITS_PER_BYTE - 1);

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;

    logic        sync_cs_n, sync_sclk, sync_mosi, sync_dc;
    logic        sclk_prev_q, cs_prev_q;
    logic        sclk_rise, cs_rise;
    logic [6:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        push_q, push_d;
    oled_byte_t  push_byte_q, push_byte_d;
    logic        overflow_q, overflow_d;
    logic        frag_q, frag_d;
    logic [15:0] count_q, count_d;

    logic        fifo_full, fifo_empty, pop;
    oled_byte_t  head;

    assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    assign dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], oled_dc};

    assign sync_cs_n = cs_sync_q[SYNC_STAGES-1];
    assign sync_sclk = sclk_sync_q[SYNC_STAGES-1];
    assign sync_mosi = mosi_sync_q[SYNC_STAGES-1];
    assign sync_dc   = dc_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sync_sclk & ~sclk_prev_q;
    assign cs_rise   = sync_cs_n & ~cs_prev_q;

    assign pop = rx_valid & rx_ready;

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        frag_d      = 1'b0;
        // Deselect aborts any partial byte; sclk activity is ignored while deselected.
        if (sync_cs_n) begin
            frag_d    = cs_rise & (bit_cnt_q != 3'd0);
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            shift_d = {shift_q[5:0], sync_mosi};
            if (bit_cnt_q == LAST_BIT) begin
                push_d           = 1'b1;
                push_byte_d.dc   = sync_dc;
                push_byte_d.data = {shift_q, sync_mosi};
                bit_cnt_d        = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end

        count_d = count_q + 16'(push_q);

        overflow_d = overflow_q;
        if (clear_overflow) begin
            overflow_d = 1'b0;
        end
        if (push_q && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            overflow_q  <= 1'b0;
            frag_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            dc_sync_q   <= dc_sync_d;
            sclk_prev_q <= sync_sclk;
            cs_prev_q   <= sync_cs_n;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            overflow_q  <= overflow_d;
            frag_q      <= frag_d;
            count_q     <= count_d;
        end
    end

    oled_sync_fifo #(
        .WIDTH ($bits(oled_byte_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .din   (push_byte_q),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_valid   = ~fifo_empty;
    assign rx_data    = head.data;
    assign rx_is_data = head.dc;
    assign overflow   = overflow_q;
    assign frag_err   = frag_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Bench for oled_spi_rx: drives the 4-wire link at a slow SCLK and checks the
// drained bytes, counters and flags against a queue-based model of the link.
module tb_oled_spi_rx;
    import oled_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        oled_dc = 1'b0;
    logic        rx_ready = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_is_data;
    logic        rx_valid;
    logic        overflow;
    logic        frag_err;
    logic [15:0] byte_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bytes the consumer should see, in order, plus counters/flags.
    logic [8:0]  model_q[$];
    logic [15:0] model_cnt = 16'd0;
    logic        model_ovf = 1'b0;
    int          frag_seen = 0;

    always #5 clk = ~clk;

    oled_spi_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi_cs_n       (spi_cs_n),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .oled_dc        (oled_dc),
        .rx_data        (rx_data),
        .rx_is_data     (rx_is_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .frag_err       (frag_err),
        .byte_count     (byte_count)
    );

    // Consumer side: every accepted head must match the model's oldest byte.
    always begin
        @(negedge clk);
        #1;
        if (frag_err) frag_seen++;
        if (rst_n && rx_valid && rx_ready) begin
            n_tests++;
            if (model_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got dc=%0d data=%02h, model expects nothing", rx_is_data, rx_data);
            end else begin
                logic [8:0] exp;
                exp = model_q.pop_front();
                if ({rx_is_data, rx_data} !== exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got dc=%0d data=%02h, expected dc=%0d data=%02h",
                             rx_is_data, rx_data, exp[8], exp[7:0]);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic model_push(input logic [8:0] b, input bit pop_same);
        model_cnt++;
        if (model_q.size() >= DEPTH && !pop_same) model_ovf = 1'b1;
        else model_q.push_back(b);
    endtask

    // Sends the top nbits of d MSB-first; only a full 8-bit transfer is a byte.
    task automatic spi_bits(input logic [7:0] d, input int nbits, input logic dcv, input bit pulse_ready);
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = d[i];
            oled_dc  = dcv;
            repeat (3) @(negedge clk);
            spi_sclk = 1'b1;
            if (i == 0 && nbits == 8) begin
                model_push({dcv, d}, pulse_ready);
                if (pulse_ready) begin
                    // Lands the pop on the same cycle the byte is pushed.
                    repeat (3) @(negedge clk);
                    rx_ready = 1'b1;
                    @(negedge clk);
                    rx_ready = 1'b0;
                end else begin
                    repeat (3) @(negedge clk);
                end
            end else begin
                repeat (3) @(negedge clk);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        rx_ready = 1'b1;
        while (model_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        rx_ready = 1'b0;
        #1;
        n_tests++;
        if (model_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes still expected, required 0", model_q.size());
        end
        n_tests++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: rx_valid=%0d, required 0", rx_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        #1;
        n_tests++; if (rx_valid !== 1'b0)      begin n_fail++; $display("FAIL reset_valid: got %0d, required 0", rx_valid); end
        n_tests++; if (rx_data !== 8'h00)      begin n_fail++; $display("FAIL reset_data: got %02h, required 00", rx_data); end
        n_tests++; if (rx_is_data !== 1'b0)    begin n_fail++; $display("FAIL reset_is_data: got %0d, required 0", rx_is_data); end
        n_tests++; if (overflow !== 1'b0)      begin n_fail++; $display("FAIL reset_overflow: got %0d, required 0", overflow); end
        n_tests++; if (frag_err !== 1'b0)      begin n_fail++; $display("FAIL reset_frag: got %0d, required 0", frag_err); end
        n_tests++; if (byte_count !== 16'd0)   begin n_fail++; $display("FAIL reset_count: got %0d, required 0", byte_count); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_cmd();
        logic [7:0] b;
        b = 8'hAF;
        cs_low();
        spi_bits(b, 7, OLED_DC_CMD, 1'b0);
        spi_mosi = b[0];
        repeat (3) @(negedge clk);
        spi_sclk = 1'b1;
        model_push({OLED_DC_CMD, b}, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: rx_valid=%0d one clk before due, required 0", rx_valid); end
        @(negedge clk);
        #1;
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL latency_due: rx_valid=%0d, required 1", rx_valid); end
        spi_sclk = 1'b0;
        cs_high();
        #1;
        n_tests++; if (rx_valid !== 1'b1)     begin n_fail++; $display("FAIL single_valid: got %0d, required 1", rx_valid); end
        n_tests++; if (rx_data !== 8'hAF)     begin n_fail++; $display("FAIL single_data: got %02h, required AF", rx_data); end
        n_tests++; if (rx_is_data !== 1'b0)   begin n_fail++; $display("FAIL single_dc: got %0d, required 0", rx_is_data); end
        n_tests++; if (byte_count !== model_cnt) begin n_fail++; $display("FAIL single_count: got %0d, required %0d", byte_count, model_cnt); end
        n_tests++; if (frag_seen != 0)        begin n_fail++; $display("FAIL single_frag: got %0d pulses, required 0", frag_seen); end
        drain();
    endtask

    task automatic test_burst();
        logic [7:0] msg [5];
        msg = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        rx_ready = 1'b1;
        cs_low();
        foreach (msg[i]) spi_bits(msg[i], 8, OLED_DC_DATA, 1'b0);
        cs_high();
        drain();
        n_tests++; if (byte_count !== model_cnt) begin n_fail++; $display("FAIL burst_count: got %0d, required %0d", byte_count, model_cnt); end
    endtask

    task automatic test_overflow();
        rx_ready = 1'b0;
        cs_low();
        for (int i = 1; i <= 5; i++) spi_bits(8'(i), 8, OLED_DC_DATA, 1'b0);
        cs_high();
        #1;
        n_tests++; if (overflow !== model_ovf)   begin n_fail++; $display("FAIL ovf_set: got %0d, required %0d", overflow, model_ovf); end
        n_tests++; if (byte_count !== model_cnt) begin n_fail++; $display("FAIL ovf_count: got %0d, required %0d", byte_count, model_cnt); end
        n_tests++; if (rx_data !== 8'h01)        begin n_fail++; $display("FAIL ovf_head_stable: got %02h, required 01", rx_data); end
        @(negedge clk);
        clear_overflow = 1'b1;
        model_ovf = 1'b0;
        @(negedge clk);
        clear_overflow = 1'b0;
        #1;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0d, required 0", overflow); end
        drain();
    endtask

    task automatic test_frag();
        int frag_before;
        int cnt_before;
        frag_before = frag_seen;
        cnt_before  = int'(model_cnt);
        cs_low();
        spi_bits(8'($urandom), 5, 1'b1, 1'b0);
        cs_high();
        n_tests++; if (frag_seen != frag_before + 1) begin n_fail++; $display("FAIL frag_pulse: got %0d pulses, required 1", frag_seen - frag_before); end
        n_tests++; if (byte_count !== 16'(cnt_before)) begin n_fail++; $display("FAIL frag_nopush: count %0d, required %0d", byte_count, cnt_before); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL frag_valid: got %0d, required 0", rx_valid); end
        cs_low();
        spi_bits(8'h3C, 8, OLED_DC_CMD, 1'b0);
        cs_high();
        n_tests++; if (frag_seen != frag_before + 1) begin n_fail++; $display("FAIL frag_silent: got %0d pulses, required 1", frag_seen - frag_before); end
        drain();
    endtask

    task automatic test_cs_high_edges();
        int frag_before;
        frag_before = frag_seen;
        for (int i = 0; i < 12; i++) begin
            spi_mosi = 1'($urandom);
            repeat (3) @(negedge clk);
            spi_sclk = ~spi_sclk;
        end
        spi_sclk = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        n_tests++; if (byte_count !== model_cnt) begin n_fail++; $display("FAIL idle_edges_count: got %0d, required %0d", byte_count, model_cnt); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_edges_valid: got %0d, required 0", rx_valid); end
        n_tests++; if (frag_seen != frag_before) begin n_fail++; $display("FAIL idle_edges_frag: got %0d pulses, required 0", frag_seen - frag_before); end
    endtask

    task automatic test_reset_midbyte();
        logic [7:0] b;
        rx_ready = 1'b0;
        cs_low();
        spi_bits(8'($urandom), 8, 1'b1, 1'b0);
        spi_bits(8'($urandom), 4, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_q.delete();
        model_cnt = 16'd0;
        model_ovf = 1'b0;
        @(negedge clk);
        #1;
        n_tests++; if (rx_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_valid: got %0d, required 0", rx_valid); end
        n_tests++; if (rx_data !== 8'h00)    begin n_fail++; $display("FAIL rst_mid_data: got %02h, required 00", rx_data); end
        n_tests++; if (byte_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d, required 0", byte_count); end
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        b = 8'($urandom);
        cs_low();
        spi_bits(b, 8, OLED_DC_DATA, 1'b0);
        cs_high();
        #1;
        n_tests++; if ({rx_valid, rx_is_data, rx_data} !== {2'b11, b}) begin
            n_fail++; $display("FAIL rst_mid_next: got v=%0d dc=%0d %02h, required v=1 dc=1 %02h", rx_valid, rx_is_data, rx_data, b);
        end
        n_tests++; if (byte_count !== 16'd1) begin n_fail++; $display("FAIL rst_mid_next_count: got %0d, required 1", byte_count); end
        drain();
    endtask

    task automatic test_push_pop_full();
        rx_ready = 1'b0;
        cs_low();
        for (int i = 0; i < DEPTH; i++) spi_bits(8'($urandom), 8, 1'($urandom), 1'b0);
        spi_bits(8'hC5, 8, OLED_DC_DATA, 1'b1);
        cs_high();
        #1;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_ovf: got %0d, required 0", overflow); end
        n_tests++; if (byte_count !== model_cnt) begin n_fail++; $display("FAIL pushpop_count: got %0d, required %0d", byte_count, model_cnt); end
        drain();
    endtask

    task automatic test_random();
        int left;
        left = 24;
        rx_ready = 1'b1;
        while (left > 0) begin
            int n;
            n = int'($urandom_range(1, 4));
            if (n > left) n = left;
            cs_low();
            for (int i = 0; i < n; i++) spi_bits(8'($urandom), 8, 1'($urandom), 1'b0);
            cs_high();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            left -= n;
        end
        drain();
        n_tests++; if (byte_count !== model_cnt) begin n_fail++; $display("FAIL random_count: got %0d, required %0d", byte_count, model_cnt); end
        n_tests++; if (overflow !== model_ovf)   begin n_fail++; $display("FAIL random_ovf: got %0d, required %0d", overflow, model_ovf); end
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_burst();
        test_overflow();
        test_frag();
        test_cs_high_edges();
        test_push_pop_full();
        test_random();
        test_reset_midbyte();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
